// File: rtl/tdp_bram_pkg.sv
// Shared constants for the true dual-port block RAM.
// Define TDP_BRAM_OUT_REG_EN to add a second output register per port (read latency 2).
package tdp_bram_pkg;

  typedef enum logic {
    WM_READ_FIRST  = 1'b0,
    WM_WRITE_FIRST = 1'b1
  } write_mode_e;

  typedef enum logic {
    COLL_A_WINS = 1'b0,
    COLL_B_WINS = 1'b1
  } collision_e;

  localparam write_mode_e WRITE_MODE = WM_READ_FIRST;
  localparam collision_e  COLLISION  = COLL_B_WINS;

`ifdef TDP_BRAM_OUT_REG_EN
  localparam int READ_LATENCY = 2;
`else
  localparam int READ_LATENCY = 1;
`endif

endpackage

// File: rtl/tdp_bram_port.sv
// Per-port read output pipeline: one registered stage, plus a second stage
// when TDP_BRAM_OUT_REG_EN selects a read latency of 2.
module tdp_bram_port
  import tdp_bram_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] dout
);

  // Output registers start at zero so dout is defined before the first edge.
  logic [DATA_WIDTH-1:0] dout_p0 = '0;

  // Stage p0: registered array read.
  always_ff @(posedge clk) begin
    if (rst) dout_p0 <= '0;
    else     dout_p0 <= rd_data;
  end

  if (READ_LATENCY == 2) begin : g_out_reg
    logic [DATA_WIDTH-1:0] dout_p1 = '0;

    // Stage p1: optional extra output register.
    always_ff @(posedge clk) begin
      if (rst) dout_p1 <= '0;
      else     dout_p1 <= dout_p0;
    end

    assign dout = dout_p1;
  end else begin : g_no_out_reg
    assign dout = dout_p0;
  end

endmodule

// File: rtl/tdp_bram_sync.sv
// True dual-port synchronous RAM, read-first on both ports, port B wins a
// same-address write collision. TDP_BRAM_OUT_REG_EN adds a second output register.
module tdp_bram_sync
  import tdp_bram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta,
  input  logic                  web,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dinb,
  output logic [DATA_WIDTH-1:0] doutb
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Zero-initialised contents; reset never touches the array.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic                  same_addr;
  logic                  wr_a;
  logic                  wr_b;
  logic [DATA_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_b;

  assign same_addr = (addra == addrb);
  assign wr_a      = wea && !(web && same_addr && (COLLISION == COLL_B_WINS));
  assign wr_b      = web && !(wea && same_addr && (COLLISION == COLL_A_WINS));

  // Read-first: the array value before this edge's write is what gets registered.
  assign rd_a = (WRITE_MODE == WM_WRITE_FIRST && wea) ? dina : mem[addra];
  assign rd_b = (WRITE_MODE == WM_WRITE_FIRST && web) ? dinb : mem[addrb];

  always_ff @(posedge clk) begin
    if (wr_a) mem[addra] <= dina;
    if (wr_b) mem[addrb] <= dinb;
  end

  tdp_bram_port #(.DATA_WIDTH(DATA_WIDTH)) u_port_a (
    .clk     (clk),
    .rst     (rst),
    .rd_data (rd_a),
    .dout    (douta)
  );

  tdp_bram_port #(.DATA_WIDTH(DATA_WIDTH)) u_port_b (
    .clk     (clk),
    .rst     (rst),
    .rd_data (rd_b),
    .dout    (doutb)
  );

endmodule

// File: tb/tb_tdp_bram_sync.sv
// Bench for tdp_bram_sync: directed vector table on a 32x256 instance, then
// randomized traffic on 1x16 and 512x256 instances against array models.
module tb_tdp_bram_sync;
  import tdp_bram_pkg::*;

  localparam int LAT = READ_LATENCY;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32-bit / 8-bit address instance
  logic        wea_m, web_m;
  logic [7:0]  addra_m, addrb_m;
  logic [31:0] dina_m, dinb_m, douta_m, doutb_m;
  // 1-bit / 4-bit address instance
  logic        wea_s, web_s;
  logic [3:0]  addra_s, addrb_s;
  logic [0:0]  dina_s, dinb_s, douta_s, doutb_s;
  // 512-bit / 8-bit address instance
  logic         wea_w, web_w;
  logic [7:0]   addra_w, addrb_w;
  logic [511:0] dina_w, dinb_w, douta_w, doutb_w;

  tdp_bram_sync #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) u_dut_m (
    .clk(clk), .rst(rst),
    .wea(wea_m), .addra(addra_m), .dina(dina_m), .douta(douta_m),
    .web(web_m), .addrb(addrb_m), .dinb(dinb_m), .doutb(doutb_m));

  tdp_bram_sync #(.DATA_WIDTH(1), .ADDR_WIDTH(4)) u_dut_s (
    .clk(clk), .rst(rst),
    .wea(wea_s), .addra(addra_s), .dina(dina_s), .douta(douta_s),
    .web(web_s), .addrb(addrb_s), .dinb(dinb_s), .doutb(doutb_s));

  tdp_bram_sync #(.DATA_WIDTH(512), .ADDR_WIDTH(8)) u_dut_w (
    .clk(clk), .rst(rst),
    .wea(wea_w), .addra(addra_w), .dina(dina_w), .douta(douta_w),
    .web(web_w), .addrb(addrb_w), .dinb(dinb_w), .doutb(doutb_w));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  typedef struct {
    logic        wea;
    logic [7:0]  addra;
    logic [31:0] dina;
    logic        web;
    logic [7:0]  addrb;
    logic [31:0] dinb;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs[13];

  // Reference models for the random phase
  logic [511:0] mdl_w [256];
  logic         mdl_s [16];
  logic [511:0] qa_w[$], qb_w[$];
  logic         qa_s[$], qb_s[$];

  initial begin
    // wea addra dina web addrb dinb -> expected douta doutb (reads issued this cycle)
    vecs[0]  = '{1'b0, 8'h00, 32'h0,        1'b0, 8'hFF, 32'h0,        32'h0,        32'h0};
    vecs[1]  = '{1'b1, 8'h05, 32'hDEADBEEF, 1'b0, 8'h10, 32'h0,        32'h0,        32'h0};
    vecs[2]  = '{1'b0, 8'h00, 32'h0,        1'b0, 8'h05, 32'h0,        32'h0,        32'hDEADBEEF};
    vecs[3]  = '{1'b1, 8'h10, 32'h7,        1'b0, 8'h05, 32'h0,        32'h0,        32'hDEADBEEF};
    vecs[4]  = '{1'b1, 8'h10, 32'h11,       1'b0, 8'h10, 32'h0,        32'h7,        32'h7};
    vecs[5]  = '{1'b0, 8'h10, 32'h0,        1'b0, 8'h10, 32'h0,        32'h11,       32'h11};
    vecs[6]  = '{1'b1, 8'h20, 32'hAAAA,     1'b1, 8'h20, 32'h5555,     32'h0,        32'h0};
    vecs[7]  = '{1'b0, 8'h20, 32'h0,        1'b0, 8'h20, 32'h0,        32'h5555,     32'h5555};
    vecs[8]  = '{1'b1, 8'h30, 32'h1,        1'b1, 8'h31, 32'h2,        32'h0,        32'h0};
    vecs[9]  = '{1'b0, 8'h31, 32'h0,        1'b0, 8'h30, 32'h0,        32'h2,        32'h1};
    vecs[10] = '{1'b1, 8'hFF, 32'h12345678, 1'b0, 8'hFF, 32'h0,        32'h0,        32'h0};
    vecs[11] = '{1'b0, 8'hFF, 32'h0,        1'b1, 8'hFF, 32'h9,        32'h12345678, 32'h12345678};
    vecs[12] = '{1'b0, 8'hFF, 32'h0,        1'b0, 8'h00, 32'h0,        32'h9,        32'h0};

    rst = 1'b1;
    wea_m = 0; web_m = 0; addra_m = 0; addrb_m = 8'hFF; dina_m = 0; dinb_m = 0;
    wea_s = 0; web_s = 0; addra_s = 0; addrb_s = 0;     dina_s = 0; dinb_s = 0;
    wea_w = 0; web_w = 0; addra_w = 0; addrb_w = 0;     dina_w = 0; dinb_w = 0;

    #1;
    chk("powerup_douta", douta_m, 0);
    chk("powerup_doutb", doutb_m, 0);
    step();
    chk("reset_douta", douta_m, 0);
    chk("reset_doutb", doutb_m, 0);
    rst = 1'b0;

    // Directed table; vector j's reads are checked LAT edges after being issued
    for (int i = 0; i < 13 + LAT - 1; i++) begin
      if (i < 13) begin
        wea_m = vecs[i].wea; addra_m = vecs[i].addra; dina_m = vecs[i].dina;
        web_m = vecs[i].web; addrb_m = vecs[i].addrb; dinb_m = vecs[i].dinb;
      end else begin
        wea_m = 0; web_m = 0; addra_m = 0; addrb_m = 0;
      end
      step();
      if (i - (LAT - 1) >= 0) begin
        chk($sformatf("vec%0d_douta", i - (LAT - 1)), douta_m, vecs[i - (LAT - 1)].exp_a);
        chk($sformatf("vec%0d_doutb", i - (LAT - 1)), doutb_m, vecs[i - (LAT - 1)].exp_b);
      end
    end

    // Mid-stream reset: outputs nonzero, rst clears them, writes still land
    wea_m = 0; web_m = 0; addra_m = 8'hFF; addrb_m = 8'h05;
    repeat (LAT) step();
    chk("pre_rst_douta", douta_m, 32'h9);
    chk("pre_rst_doutb", doutb_m, 32'hDEADBEEF);
    rst = 1'b1; wea_m = 1; addra_m = 8'h40; dina_m = 32'h77;
    step();
    chk("mid_rst_douta", douta_m, 0);
    chk("mid_rst_doutb", doutb_m, 0);
    rst = 1'b0; wea_m = 0;
    repeat (LAT) step();
    chk("post_rst_douta", douta_m, 32'h77);
    chk("post_rst_doutb", doutb_m, 32'hDEADBEEF);

    // Randomized parallel traffic on the narrow and wide instances
    for (int a = 0; a < 256; a++) mdl_w[a] = '0;
    for (int a = 0; a < 16; a++)  mdl_s[a] = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      wea_w = $urandom_range(0, 1);
      web_w = $urandom_range(0, 1);
      addra_w = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      addrb_w = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      dina_w = rand512();
      dinb_w = rand512();
      wea_s = $urandom_range(0, 1);
      web_s = $urandom_range(0, 1);
      addra_s = 4'($urandom);
      addrb_s = 4'($urandom);
      dina_s = 1'($urandom);
      dinb_s = 1'($urandom);

      qa_w.push_back(mdl_w[addra_w]);
      qb_w.push_back(mdl_w[addrb_w]);
      qa_s.push_back(mdl_s[addra_s]);
      qb_s.push_back(mdl_s[addrb_s]);
      // A's write first, then B's, so B wins a shared address
      if (wea_w) mdl_w[addra_w] = dina_w;
      if (web_w) mdl_w[addrb_w] = dinb_w;
      if (wea_s) mdl_s[addra_s] = dina_s;
      if (web_s) mdl_s[addrb_s] = dinb_s;

      step();
      if (qa_w.size() == LAT) begin
        chk($sformatf("rnd%0d_w_douta", c), douta_w, qa_w.pop_front());
        chk($sformatf("rnd%0d_w_doutb", c), doutb_w, qb_w.pop_front());
        chk($sformatf("rnd%0d_s_douta", c), 512'(douta_s), 512'(qa_s.pop_front()));
        chk($sformatf("rnd%0d_s_doutb", c), 512'(doutb_s), 512'(qb_s.pop_front()));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
